// File: rtl/phase_sequencer.sv
// -----------------------------------------------------------------------------
// phase_sequencer
//
// Five-phase instruction sequencer: fetch (P1), decode (P2), execute (P3),
// memory (P4), writeback (P5). Each instruction takes exactly five cycles.
// Datapath strobes are decoded from the current state and the instruction
// word. The data-selector switches are registered on the edge leaving P2.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   run        in   one-cycle start/resume pulse (from IDLE or HALT)
//   stop       in   one-cycle pulse, stop after the current instruction
//   op[15:0]   in   instruction word, valid from P2 onward
//   phase[4:0] out  one-hot P1..P5 (bit0 = P1), zero when not executing
//   ir_load    out  instruction register load (P1)
//   pc_load    out  program counter load (P5, not on HLT)
//   mem_write  out  memory write strobe (P4, store)
//   reg_write  out  register file write strobe (P5, writing instructions)
//   switch1..6 out  registered data-selector controls
//   running    out  executing P1..P5
//   halted     out  sitting in HALT
//
// Build option
//   PHASE_STEP_MODE_EN  when defined, every non-HLT instruction returns to
//                       IDLE after P5, so each run pulse executes one
//                       instruction. When undefined, the sequencer free-runs
//                       until a stop is recorded or a HLT is executed.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | not executing, waiting for run
// P1    | fetch, instruction register loads
// P2    | decode, switches captured on exit
// P3    | execute
// P4    | memory access, store writes here
// P5    | writeback and PC update, choose next instruction or stop
// HALT  | HLT executed, waiting for run
// -----------------------------------------------------------------------------
module phase_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        stop,
    input  logic [15:0] op,
    output logic [4:0]  phase,
    output logic        ir_load,
    output logic        pc_load,
    output logic        mem_write,
    output logic        reg_write,
    output logic        switch1,
    output logic        switch2,
    output logic        switch3,
    output logic        switch4,
    output logic        switch5,
    output logic        switch6,
    output logic        running,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_P1   = 3'd1,
        S_P2   = 3'd2,
        S_P3   = 3'd3,
        S_P4   = 3'd4,
        S_P5   = 3'd5,
        S_HALT = 3'd6
    } state_t;

    state_t     state, state_next;
    logic       stop_pending, stop_pending_next;
    logic [5:0] sw_q;

    logic [1:0] op_class;
    logic [3:0] op_func;
    logic       is_hlt;
    logic       is_store;
    logic       writes_reg;
    logic       in_phase;
    logic       unused_op_bits;

    assign op_class = op[15:14];
    assign op_func  = op[7:4];
    assign is_hlt   = (op_class == 2'b11) && (op_func == 4'b1111);
    assign is_store = (op_class == 2'b01);

    // Loads, immediate loads and every ALU-class op except the two
    // non-writing functions and HLT update the register file.
    assign writes_reg = (op_class == 2'b00) ||
                        ((op_class == 2'b10) && (op[13:11] == 3'b000)) ||
                        ((op_class == 2'b11) && (op_func != 4'b0101) &&
                         (op_func != 4'b0110) && (op_func != 4'b1111));

    assign unused_op_bits = ^{op[10:8], op[3:0]};

    assign in_phase = (state == S_P1) || (state == S_P2) || (state == S_P3) ||
                      (state == S_P4) || (state == S_P5);

    // -------------------------------------------------------------------------
    // State, stop flag and switch registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            stop_pending <= 1'b0;
            sw_q         <= 6'b0;
        end else begin
            state        <= state_next;
            stop_pending <= stop_pending_next;
            if (state == S_P2) begin
                sw_q <= {(op_class == 2'b01),                            // switch6
                         (op_class == 2'b10),                            // switch5
                         ((op_class == 2'b11) && (op_func == 4'b1100)),  // switch4
                         (op_class == 2'b10),                            // switch3
                         (op_class == 2'b10),                            // switch2
                         (op_class == 2'b10)};                           // switch1
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next state and stop flag
    // -------------------------------------------------------------------------
    always_comb begin
        state_next        = state;
        stop_pending_next = stop_pending;

        case (state)
            S_IDLE, S_HALT: begin
                // stop wins over a simultaneous run
                if (run && !stop) begin
                    state_next = S_P1;
                end
            end
            S_P1: state_next = S_P2;
            S_P2: state_next = S_P3;
            S_P3: state_next = S_P4;
            S_P4: state_next = S_P5;
            S_P5: begin
                // a stop arriving in P5 itself still ends this run
                if (is_hlt) begin
                    state_next = S_HALT;
`ifdef PHASE_STEP_MODE_EN
                end else begin
                    state_next = S_IDLE;
                end
`else
                end else if (stop_pending || stop) begin
                    state_next = S_IDLE;
                end else begin
                    state_next = S_P1;
                end
`endif
            end
            default: state_next = S_IDLE;
        endcase

        if (in_phase && stop) begin
            stop_pending_next = 1'b1;
        end
        if ((state_next == S_IDLE) || (state_next == S_HALT)) begin
            stop_pending_next = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: decoded from state (and the instruction word) only
    // -------------------------------------------------------------------------
    always_comb begin
        phase     = 5'b00000;
        ir_load   = 1'b0;
        pc_load   = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;

        case (state)
            S_P1: begin
                phase   = 5'b00001;
                ir_load = 1'b1;
            end
            S_P2: phase = 5'b00010;
            S_P3: phase = 5'b00100;
            S_P4: begin
                phase     = 5'b01000;
                mem_write = is_store;
            end
            S_P5: begin
                phase     = 5'b10000;
                reg_write = writes_reg;
                pc_load   = !is_hlt;
            end
            default: ;
        endcase
    end

    assign running = in_phase;
    assign halted  = (state == S_HALT);

    assign switch1 = sw_q[0];
    assign switch2 = sw_q[1];
    assign switch3 = sw_q[2];
    assign switch4 = sw_q[3];
    assign switch5 = sw_q[4];
    assign switch6 = sw_q[5];

endmodule

// File: tb/tb_phase_sequencer.sv
// -----------------------------------------------------------------------------
// tb_phase_sequencer
//
// Directed bench for phase_sequencer: walks instructions phase by phase and
// compares phases, strobes, switches and status against hand-worked values.
// -----------------------------------------------------------------------------
module tb_phase_sequencer;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic        stop;
    logic [15:0] op;
    logic [4:0]  phase;
    logic        ir_load, pc_load, mem_write, reg_write;
    logic        switch1, switch2, switch3, switch4, switch5, switch6;
    logic        running, halted;
    logic [5:0]  sw;

    int n_tests;
    int n_fail;

    phase_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .stop      (stop),
        .op        (op),
        .phase     (phase),
        .ir_load   (ir_load),
        .pc_load   (pc_load),
        .mem_write (mem_write),
        .reg_write (reg_write),
        .switch1   (switch1),
        .switch2   (switch2),
        .switch3   (switch3),
        .switch4   (switch4),
        .switch5   (switch5),
        .switch6   (switch6),
        .running   (running),
        .halted    (halted)
    );

    assign sw = {switch6, switch5, switch4, switch3, switch2, switch1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one instruction from IDLE/HALT and check every phase.
    // do_stop pulses stop in P3; ends one cycle after P5 when the run ends.
    task automatic run_instr(input string name, input logic [15:0] op_val,
                             input logic do_stop, input logic exp_mw,
                             input logic exp_rw, input logic exp_pc,
                             input logic [5:0] exp_sw, input logic exp_hlt);
        op  = op_val;
        run = 1'b1;
        tick();
        run = 1'b0;
        check({name, "_p1_phase"}, 8'(phase), 8'h01);
        check({name, "_p1_ir_load"}, 8'(ir_load), 8'h1);
        check({name, "_p1_running"}, 8'(running), 8'h1);
        check({name, "_p1_halted"}, 8'(halted), 8'h0);
        tick();
        check({name, "_p2_phase"}, 8'(phase), 8'h02);
        check({name, "_p2_ir_load"}, 8'(ir_load), 8'h0);
        tick();
        check({name, "_p3_phase"}, 8'(phase), 8'h04);
        check({name, "_p3_switches"}, 8'(sw), 8'(exp_sw));
        check({name, "_p3_mem_write"}, 8'(mem_write), 8'h0);
        if (do_stop) stop = 1'b1;
        tick();
        stop = 1'b0;
        check({name, "_p4_phase"}, 8'(phase), 8'h08);
        check({name, "_p4_mem_write"}, 8'(mem_write), 8'(exp_mw));
        check({name, "_p4_reg_write"}, 8'(reg_write), 8'h0);
        check({name, "_p4_pc_load"}, 8'(pc_load), 8'h0);
        tick();
        check({name, "_p5_phase"}, 8'(phase), 8'h10);
        check({name, "_p5_reg_write"}, 8'(reg_write), 8'(exp_rw));
        check({name, "_p5_pc_load"}, 8'(pc_load), 8'(exp_pc));
        check({name, "_p5_mem_write"}, 8'(mem_write), 8'h0);
        if (do_stop || exp_hlt) begin
            tick();
            check({name, "_end_phase"}, 8'(phase), 8'h00);
            check({name, "_end_running"}, 8'(running), 8'h0);
            check({name, "_end_halted"}, 8'(halted), 8'(exp_hlt));
            check({name, "_end_switches"}, 8'(sw), 8'(exp_sw));
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        run     = 1'b0;
        stop    = 1'b0;
        op      = 16'h0000;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        check("rst_phase", 8'(phase), 8'h00);
        check("rst_running", 8'(running), 8'h0);
        check("rst_halted", 8'(halted), 8'h0);
        check("rst_strobes", 8'({ir_load, pc_load, mem_write, reg_write}), 8'h0);
        check("rst_switches", 8'(sw), 8'h00);

        // ADD, store, LI, ALU op 1100: each stopped in P3 so it ends in IDLE
        run_instr("add",   16'hC000, 1'b1, 1'b0, 1'b1, 1'b1, 6'b000000, 1'b0);
        run_instr("store", 16'h4000, 1'b1, 1'b1, 1'b0, 1'b1, 6'b100000, 1'b0);
        run_instr("li",    16'h8000, 1'b1, 1'b0, 1'b1, 1'b1, 6'b010111, 1'b0);
        run_instr("alu_c", 16'hC0C0, 1'b1, 1'b0, 1'b1, 1'b1, 6'b001000, 1'b0);
        // ALU function 0101 does not write the register file
        run_instr("alu_5", 16'hC050, 1'b1, 1'b0, 1'b0, 1'b1, 6'b000000, 1'b0);

        // HLT lands in HALT without any stop
        run_instr("hlt",   16'hC0F0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, 1'b1);
        tick();
        check("halt_hold", 8'(halted), 8'h1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("halt_stop_ignored", 8'(halted), 8'h1);
        run  = 1'b1;
        stop = 1'b1;
        tick();
        run  = 1'b0;
        stop = 1'b0;
        check("halt_run_stop_phase", 8'(phase), 8'h00);
        check("halt_run_stop_halted", 8'(halted), 8'h1);
        // run from HALT restarts at P1 on the next edge
        run_instr("resume", 16'hC000, 1'b1, 1'b0, 1'b1, 1'b1, 6'b000000, 1'b0);

        // run and stop together in IDLE: stop wins
        run  = 1'b1;
        stop = 1'b1;
        tick();
        run  = 1'b0;
        stop = 1'b0;
        check("idle_run_stop_phase", 8'(phase), 8'h00);
        tick();
        check("idle_run_stop_running", 8'(running), 8'h0);

        // stop alone in IDLE must not be remembered
        stop = 1'b1;
        tick();
        stop = 1'b0;
        run_instr("free", 16'hC000, 1'b0, 1'b0, 1'b1, 1'b1, 6'b000000, 1'b0);
        tick();
`ifdef PHASE_STEP_MODE_EN
        check("step_after_p5_phase", 8'(phase), 8'h00);
        check("step_after_p5_running", 8'(running), 8'h0);
`else
        check("free_next_p1_phase", 8'(phase), 8'h01);
        stop = 1'b1;                       // stop in P1 of the follow-on instruction
        tick();
        stop = 1'b0;
        run  = 1'b1;                       // run mid-instruction is ignored
        tick();
        run  = 1'b0;
        check("free_p3_phase", 8'(phase), 8'h04);
        tick();
        tick();
        check("free_p5_phase", 8'(phase), 8'h10);
        tick();
        check("free_stop_idle_phase", 8'(phase), 8'h00);
        check("free_stop_idle_running", 8'(running), 8'h0);
`endif

        // asynchronous reset in P3 clears everything before the next edge
        op  = 16'h8000;
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        tick();
        check("arst_pre_phase", 8'(phase), 8'h04);
        check("arst_pre_switches", 8'(sw), 8'h17);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_phase", 8'(phase), 8'h00);
        check("arst_running", 8'(running), 8'h0);
        check("arst_switches", 8'(sw), 8'h00);
        check("arst_strobes", 8'({ir_load, pc_load, mem_write, reg_write, halted}), 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("arst_release_phase", 8'(phase), 8'h00);
        run_instr("post_rst", 16'hC000, 1'b1, 1'b0, 1'b1, 1'b1, 6'b000000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/phase_sequencer.md
PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 The block SHALL expose: clk  in  1  sole clock, rising-edge.
REQ-002 The block SHALL expose: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 The block SHALL expose: run  in  1  one-cycle start/resume pulse.
REQ-004 The block SHALL expose: stop  in  1  one-cycle pulse; stop after current instruction.
REQ-005 The block SHALL expose: op  in  16  instruction word from instruction register, valid from P2 onward.
REQ-006 The block SHALL expose: phase  out  5  one-hot P1..P5 (bit0=P1), all zero when not executing.
REQ-007 The block SHALL expose: ir_load, pc_load, mem_write, reg_write  out  1 each  datapath strobes.
REQ-008 The block SHALL expose: switch1..switch6  out  1 each  registered data-selector controls.
REQ-009 The block SHALL expose: running, halted  out  1 each  status.

Function
REQ-010 States SHALL be IDLE, P1 (fetch), P2 (decode), P3 (execute), P4 (memory), P5 (writeback), HALT; one state per cycle.
REQ-011 IDLE: run=1 -> P1 next cycle; otherwise stay.
REQ-012 P1->P2->P3->P4->P5 unconditionally; instruction latency SHALL be exactly 5 cycles.
REQ-013 P5 -> HALT if op is HLT (op[15:14]=11, op[7:4]=1111); else IDLE if a stop was recorded; else P1.
REQ-014 HALT: run=1 -> P1; stop ignored; halted=1 for as long as the state is HALT.
REQ-015 A stop pulse in any of P1..P5 SHALL set a stop_pending flag, cleared on entry to IDLE or HALT; stop in IDLE has no effect.
REQ-016 run and stop in the same cycle while in IDLE or HALT: stop wins; the state is unchanged.
REQ-017 run during P1..P5 SHALL be ignored.
REQ-018 ir_load SHALL be 1 only in P1.
REQ-019 mem_write SHALL be 1 only in P4 when op[15:14]=01 (store).
REQ-020 reg_write SHALL be 1 only in P5 when: op[15:14]=00 (load); or op[15:14]=10 and op[13:11]=000 (immediate load); or op[15:14]=11 and op[7:4] not in {0101, 0110, 1111}.
REQ-021 pc_load SHALL be 1 in P5 unless the instruction is HLT.
REQ-022 switch1..6 SHALL be captured at the clock edge leaving P2 and held until the next P2 exit: switch1=switch2=switch3=switch5=(op[15:14]=10); switch4=(op[15:14]=11 and op[7:4]=1100); switch6=(op[15:14]=01).
REQ-023 running SHALL be 1 in P1..P5.
REQ-024 All outputs SHALL be registered or decoded from state only; none SHALL depend combinationally on run or stop.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE, stop_pending=0, and every output to 0, including from any mid-instruction phase.
REQ-026 After rst_n deasserts, the first run pulse SHALL start P1 on the following edge.

Configuration
REQ-027 Macro PHASE_STEP_MODE_EN defined: P5 of a non-HLT instruction SHALL always go to IDLE, so each run pulse executes exactly one instruction.
REQ-028 Macro PHASE_STEP_MODE_EN undefined: the block SHALL free-run per REQ-013.

Verification
REQ-029 Reset, then run pulse with op=16'hC000 (ADD) -> phase 00001,00010,00100,01000,10000; ir_load in cycle 1; reg_write=1 and pc_load=1 in cycle 5; all switches 0.
REQ-030 op=16'h4000 (store) -> mem_write=1 in P4 only, reg_write=0 in P5; switch6=1 after P2.
REQ-031 op=16'h8000 (LI) -> switch1,2,3,5=1; reg_write=1 in P5. op=16'hC0C0 -> switch4=1 only.
REQ-032 op=16'hC0F0 (HLT) -> pc_load=0 in P5, then halted=1; run in HALT -> P1 next cycle.
REQ-033 stop in P3 -> instruction completes through P5, then IDLE; run+stop in the same IDLE cycle -> remains IDLE.
REQ-034 rst_n pulled low during P3 -> phase=0 and all strobes/switches 0 in the same cycle, without waiting for a clock edge; with PHASE_STEP_MODE_EN defined, ADD -> IDLE after P5.
